majority_stream_sampler: RTL and testbench

- Upstream feeder for the 5-input combinational majority voter.
- Accepts a serial bit stream under valid/ready handshake and assembles WIN-bit windows presented as win_vec[WIN:1], where bit 1 is the newest and bit WIN the oldest.
- Keeps a running ones count and emits a registered majority decision per window.
- Supports block mode (non-overlapping windows) and sliding mode (one decision per new bit once full).

---
 rtl/majority_stream_sampler.sv | 89 ++++++++
 tb/tb_majority_stream_sampler.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/majority_stream_sampler.sv
// Serial-to-window front end for the majority voter: shifts a handshaked bit stream
// into a WIN-bit window, tracks the ones count and issues registered majority decisions.
module majority_stream_sampler #(
   parameter int WIN = 5,
   parameter int CW  = $clog2(WIN + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   input  logic          mode_slide,
   input  logic          in_valid,
   input  logic          in_bit,
   output logic          in_ready,
   output logic [WIN:1]  win_vec,
   output logic [CW-1:0] fill_cnt,
   output logic          out_valid,
   input  logic          out_ready,
   output logic          out_maj,
   output logic [CW-1:0] out_ones
);

   localparam logic [CW-1:0] FULL_CNT = CW'(WIN);
   localparam logic [CW-1:0] LAST_CNT = CW'(WIN - 1);
   localparam logic [CW-1:0] MAJ_TH   = CW'((WIN + 1) / 2);

   logic [CW-1:0] ones;
   logic [CW-1:0] ones_next;
   logic          mode_q;
   logic          accept;
   logic          is_full;
   logic          slide_eff;
   logic          decide;
   logic          block_done;

   assign in_ready = !out_valid || out_ready;
   assign accept   = in_valid && in_ready;
   assign is_full  = (fill_cnt == FULL_CNT);

   // An empty window has no latched mode yet, so the live input governs the first accept.
   assign slide_eff = (fill_cnt == '0) ? mode_slide : mode_q;

   // The oldest bit only falls out once the window is full; the count stays within 0..WIN.
   assign ones_next  = ones + CW'(in_bit) - CW'(is_full && win_vec[WIN]);
   assign decide     = accept && ((fill_cnt == LAST_CNT) || (is_full && slide_eff));
   assign block_done = decide && !slide_eff;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win_vec   <= '0;
         fill_cnt  <= '0;
         ones      <= '0;
         mode_q    <= 1'b0;
         out_valid <= 1'b0;
         out_maj   <= 1'b0;
         out_ones  <= '0;
      end else if (clear) begin
         win_vec   <= '0;
         fill_cnt  <= '0;
         ones      <= '0;
         out_valid <= 1'b0;
      end else begin
         if (accept) begin
            if (fill_cnt == '0) begin
               mode_q <= mode_slide;
            end
            // Block mode restarts from empty; the finished window survives only in the decision.
            if (block_done) begin
               win_vec  <= '0;
               fill_cnt <= '0;
               ones     <= '0;
            end else begin
               win_vec <= {win_vec[WIN-1:1], in_bit};
               ones    <= ones_next;
               if (!is_full) begin
                  fill_cnt <= fill_cnt + CW'(1);
               end
            end
         end
         if (decide) begin
            out_valid <= 1'b1;
            out_ones  <= ones_next;
            out_maj   <= (ones_next >= MAJ_TH);
         end else if (out_ready) begin
            out_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_majority_stream_sampler.sv
// Directed bench for majority_stream_sampler: expected decisions are queued as
// stimulus is driven and compared as each decision is handed downstream.
module tb_majority_stream_sampler;

   localparam int WIN = 5;
   localparam int CW  = $clog2(WIN + 1);

   typedef struct packed {
      logic          maj;
      logic [CW-1:0] ones;
   } res_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          clear = 1'b0;
   logic          mode_slide = 1'b0;
   logic          in_valid = 1'b0;
   logic          in_bit = 1'b0;
   logic          out_ready = 1'b1;
   logic          in_ready;
   logic [WIN:1]  win_vec;
   logic [CW-1:0] fill_cnt;
   logic          out_valid;
   logic          out_maj;
   logic [CW-1:0] out_ones;

   int   tests = 0;
   int   fails = 0;
   int   n_decisions = 0;
   int   n_maj = 0;
   logic last_accept = 1'b0;
   res_t exp_q[$];

   majority_stream_sampler #(.WIN(WIN)) dut (
      .clk(clk), .rst_n(rst_n), .clear(clear), .mode_slide(mode_slide),
      .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .win_vec(win_vec), .fill_cnt(fill_cnt), .out_valid(out_valid),
      .out_ready(out_ready), .out_maj(out_maj), .out_ones(out_ones)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Compare any decision consumed on the coming edge, then advance one cycle.
   task automatic tick();
      res_t r;
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            checkOutput("unexpected_decision", 32'(out_ones), 32'hFFFF);
         end else begin
            r = exp_q.pop_front();
            checkOutput("out_ones", 32'(out_ones), 32'(r.ones));
            checkOutput("out_maj", 32'(out_maj), 32'(r.maj));
            n_decisions++;
            n_maj += int'(out_maj);
         end
      end
      last_accept = in_valid && in_ready;
      @(posedge clk);
      #1;
   endtask

   task automatic applyStimulus(input logic b);
      bit done;
      done = 1'b0;
      in_valid = 1'b1;
      in_bit = b;
      for (int t = 0; t < 20 && !done; t++) begin
         tick();
         done = last_accept;
      end
      if (!done) checkOutput("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
   endtask

   task automatic pushExp(input logic maj, input int ones);
      res_t r;
      r.maj = maj;
      r.ones = CW'(ones);
      exp_q.push_back(r);
   endtask

   initial begin
      int dec0;
      int maj0;
      int pc;
      logic [4:0] val;

      // Reset values while rst_n is held low
      #1;
      checkOutput("rst_win_vec", 32'(win_vec), 32'd0);
      checkOutput("rst_fill_cnt", 32'(fill_cnt), 32'd0);
      checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst_out_maj", 32'(out_maj), 32'd0);
      checkOutput("rst_out_ones", 32'(out_ones), 32'd0);
      #2 rst_n = 1'b1;
      tick();
      checkOutput("rst_in_ready", 32'(in_ready), 32'd1);

      // 1: block window 1,1,0,0,1
      mode_slide = 1'b0;
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      checkOutput("t1_win_vec_4", 32'(win_vec), 32'b01100);
      checkOutput("t1_fill_4", 32'(fill_cnt), 32'd4);
      checkOutput("t1_no_dec_4", 32'(out_valid), 32'd0);
      applyStimulus(1'b1);
      pushExp(1'b1, 3);
      checkOutput("t1_out_valid", 32'(out_valid), 32'd1);
      checkOutput("t1_fill_after", 32'(fill_cnt), 32'd0);
      checkOutput("t1_win_after", 32'(win_vec), 32'd0);
      tick();
      checkOutput("t1_out_valid_one_cycle", 32'(out_valid), 32'd0);

      // 2: sliding window 1,1,1,0,0,0,0
      mode_slide = 1'b1;
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      checkOutput("t2_no_dec_4", 32'(out_valid), 32'd0);
      applyStimulus(1'b0);
      pushExp(1'b1, 3);
      applyStimulus(1'b0);
      pushExp(1'b0, 2);
      checkOutput("t2_fill_6", 32'(fill_cnt), 32'd5);
      applyStimulus(1'b0);
      pushExp(1'b0, 1);
      checkOutput("t2_fill_7", 32'(fill_cnt), 32'd5);
      checkOutput("t2_win_7", 32'(win_vec), 32'b10000);
      tick();
      checkOutput("t2_drained", 32'(out_valid), 32'd0);
      clear = 1'b1;
      tick();
      clear = 1'b0;
      checkOutput("t2_clear_fill", 32'(fill_cnt), 32'd0);

      // 3: backpressure with a pending block decision
      mode_slide = 1'b0;
      out_ready = 1'b0;
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      pushExp(1'b1, 4);
      in_valid = 1'b1;
      in_bit = 1'b1;
      for (int c = 0; c < 4; c++) begin
         checkOutput("t3_in_ready_stall", 32'(in_ready), 32'd0);
         checkOutput("t3_out_valid_hold", 32'(out_valid), 32'd1);
         checkOutput("t3_out_maj_hold", 32'(out_maj), 32'd1);
         checkOutput("t3_out_ones_hold", 32'(out_ones), 32'd4);
         checkOutput("t3_fill_hold", 32'(fill_cnt), 32'd0);
         tick();
      end
      out_ready = 1'b1;
      #1;
      checkOutput("t3_in_ready_resume", 32'(in_ready), 32'd1);
      tick();
      in_valid = 1'b0;
      checkOutput("t3_fill_resume", 32'(fill_cnt), 32'd1);
      checkOutput("t3_out_valid_cleared", 32'(out_valid), 32'd0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      pushExp(1'b0, 1);
      tick();

      // 4: all 32 five-bit patterns, oldest bit first
      dec0 = n_decisions;
      maj0 = n_maj;
      for (int i = 0; i < 32; i++) begin
         val = 5'(i);
         pc = 0;
         for (int k = 4; k >= 0; k--) begin
            applyStimulus(val[k]);
            pc += int'(val[k]);
         end
         pushExp(pc >= 3, pc);
      end
      tick();
      checkOutput("t4_decisions", 32'(n_decisions - dec0), 32'd32);
      checkOutput("t4_maj_count", 32'(n_maj - maj0), 32'd16);

      // 5: clear mid-window, then a mode toggle that must be ignored
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      checkOutput("t5_fill_3", 32'(fill_cnt), 32'd3);
      clear = 1'b1;
      in_valid = 1'b1;
      in_bit = 1'b1;
      tick();
      clear = 1'b0;
      in_valid = 1'b0;
      checkOutput("t5_clear_fill", 32'(fill_cnt), 32'd0);
      checkOutput("t5_clear_win", 32'(win_vec), 32'd0);
      checkOutput("t5_clear_no_dec", 32'(out_valid), 32'd0);
      applyStimulus(1'b0);
      applyStimulus(1'b0);
      mode_slide = 1'b1;
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b1);
      pushExp(1'b0, 2);
      checkOutput("t5_block_kept_fill", 32'(fill_cnt), 32'd0);
      checkOutput("t5_block_kept_win", 32'(win_vec), 32'd0);
      tick();

      // 6: asynchronous reset with a decision pending mid-stream
      clear = 1'b1;
      tick();
      clear = 1'b0;
      mode_slide = 1'b1;
      for (int k = 0; k < 5; k++) applyStimulus(1'b1);
      pushExp(1'b1, 5);
      applyStimulus(1'b0);
      out_ready = 1'b0;
      checkOutput("t6_pending", 32'(out_valid), 32'd1);
      #2 rst_n = 1'b0;
      #1;
      exp_q.delete();
      checkOutput("t6_rst_out_valid", 32'(out_valid), 32'd0);
      checkOutput("t6_rst_fill", 32'(fill_cnt), 32'd0);
      checkOutput("t6_rst_win", 32'(win_vec), 32'd0);
      checkOutput("t6_rst_out_ones", 32'(out_ones), 32'd0);
      checkOutput("t6_rst_out_maj", 32'(out_maj), 32'd0);
      #1 rst_n = 1'b1;
      mode_slide = 1'b0;
      out_ready = 1'b1;
      tick();
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      applyStimulus(1'b0);
      applyStimulus(1'b1);
      pushExp(1'b1, 3);
      tick();
      checkOutput("t6_fill_end", 32'(fill_cnt), 32'd0);
      checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
